// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the two-port memory arbiter.
// Ownership states and width defaults used by every arbiter file.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam int DEF_DW        = 16;
    localparam int DEF_AW        = 8;
    localparam int DEF_MAX_BURST = 16;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester, memory and status bundle for the two-port memory arbiter.
// slave = arbiter side, master = requesters plus RAM side.
interface mem_arbiter_if #(
    parameter int DW = mem_arb_pkg::DEF_DW,
    parameter int AW = mem_arb_pkg::DEF_AW
);
    logic          req0, req1;
    logic          lock0, lock1;
    logic          we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1;
    logic          rvalid0, rvalid1;
    logic [DW-1:0] rdata;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_d;
    logic          mem_we;
    logic [DW-1:0] mem_spo;
    logic [AW-1:0] highest_add;

    modport slave (
        input  req0, req1, lock0, lock1, we0, we1,
        input  addr0, addr1, wdata0, wdata1, mem_spo,
        output gnt0, gnt1, rvalid0, rvalid1, rdata,
        output mem_a, mem_d, mem_we, highest_add
    );

    modport master (
        output req0, req1, lock0, lock1, we0, we1,
        output addr0, addr1, wdata0, wdata1, mem_spo,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata,
        input  mem_a, mem_d, mem_we, highest_add
    );
endinterface

// File: rtl/mem_arb_pick.sv
// Two-way round-robin pick: on contention the requester not served last wins.
// win=0 selects requester 0, win=1 selects requester 1; any flags a request.
module mem_arb_pick (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic win,
    output logic any
);
    always_comb begin
        win = 1'b0;
        unique case (1'b1)
            (req0 & req1):  win = ~last;
            (req1 & ~req0): win = 1'b1;
            default:        win = 1'b0;
        endcase
        any = req0 | req1;
    end
endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of an async-read RAM, bursts via lock.
// Define MEM_ARB_HIGHEST_EN to build the highest-written-address tracker.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DW        = DEF_DW,
    parameter int AW        = DEF_AW,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input logic         sys_clk,
    input logic         rst,
    mem_arbiter_if.slave bus
);
    localparam int BW = $clog2(MAX_BURST) + 1;

    state_t        state, state_nxt;
    logic          last;
    logic          pick_win, pick_any;
    logic [BW-1:0] beat;
    logic          own0, own1;
    logic          req_own, lock_own;
    logic          acc, stay, rd_acc;
    logic          rvalid0_q, rvalid1_q;
    logic [DW-1:0] rdata_q;

    mem_arb_pick u_pick (
        .req0 (bus.req0),
        .req1 (bus.req1),
        .last (last),
        .win  (pick_win),
        .any  (pick_any)
    );

    assign own0 = (state == OWN0);
    assign own1 = (state == OWN1);

    assign bus.gnt0   = own0 & bus.req0;
    assign bus.gnt1   = own1 & bus.req1;
    assign bus.mem_we = (bus.gnt0 & bus.we0) | (bus.gnt1 & bus.we1);
    assign bus.mem_a  = own0 ? bus.addr0 : own1 ? bus.addr1 : '0;
    assign bus.mem_d  = own0 ? bus.wdata0 : own1 ? bus.wdata1 : '0;

    assign bus.rvalid0 = rvalid0_q;
    assign bus.rvalid1 = rvalid1_q;
    assign bus.rdata   = rdata_q;

    // beat holds accesses already made in this ownership
    always_comb begin
        req_own  = own1 ? bus.req1 : bus.req0;
        lock_own = own1 ? bus.lock1 : bus.lock0;
        acc      = (own0 | own1) & req_own;
        stay     = acc & lock_own & (beat < BW'(MAX_BURST - 1));
        rd_acc   = (bus.gnt0 & ~bus.we0) | (bus.gnt1 & ~bus.we1);
        state_nxt = state;
        unique case (state)
            IDLE: if (pick_any) state_nxt = pick_win ? OWN1 : OWN0;
            OWN0: if (!stay) state_nxt = bus.req1 ? OWN1 : IDLE;
            OWN1: if (!stay) state_nxt = bus.req0 ? OWN0 : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last      <= 1'b1;
            beat      <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt == OWN0) last <= 1'b0;
            else if (state_nxt == OWN1) last <= 1'b1;
            beat      <= stay ? beat + BW'(1) : '0;
            rvalid0_q <= bus.gnt0 & ~bus.we0;
            rvalid1_q <= bus.gnt1 & ~bus.we1;
            if (rd_acc) rdata_q <= bus.mem_spo;
        end
    end

`ifdef MEM_ARB_HIGHEST_EN
    logic [AW-1:0] hi_q;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) hi_q <= '0;
        else if (bus.mem_we && (bus.mem_a > hi_q)) hi_q <= bus.mem_a;
    end

    assign bus.highest_add = hi_q;
`else
    assign bus.highest_add = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter with a queue scoreboard.
// Reference model tracks ownership as plain integers; monitor pops on outputs.
module tb_mem_arbiter;
    localparam int DW = 16;
    localparam int AW = 8;
    localparam int MB = 16;
`ifdef MEM_ARB_HIGHEST_EN
    localparam bit HI_EN = 1'b1;
`else
    localparam bit HI_EN = 1'b0;
`endif

    logic sys_clk = 1'b0;
    logic rst = 1'b1;
    always #5 sys_clk = ~sys_clk;

    mem_arbiter_if #(.DW(DW), .AW(AW)) bus ();

    mem_arbiter #(.DW(DW), .AW(AW), .MAX_BURST(MB)) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus)
    );

    // external RAM: async read, sync write
    logic [DW-1:0] ram [256];
    assign bus.mem_spo = ram[bus.mem_a];
    always @(posedge sys_clk) if (bus.mem_we) ram[bus.mem_a] <= bus.mem_d;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        int            stamp;
        int            id;
        bit            we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } gexp_t;
    typedef struct {
        int            stamp;
        int            id;
        logic [DW-1:0] d;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];

    int            m_own = -1;
    int            m_beats = 0;
    int            m_last = 1;
    logic [AW-1:0] m_hi = '0;
    logic [DW-1:0] m_mem [256];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic drive(bit r0, bit l0, bit w0, logic [7:0] a0, logic [15:0] d0,
                         bit r1, bit l1, bit w1, logic [7:0] a1, logic [15:0] d1);
        bus.req0 = r0; bus.lock0 = l0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
        bus.req1 = r1; bus.lock1 = l1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
    endtask

    task automatic model(bit r[2], bit l[2], bit w[2], logic [7:0] a[2], logic [15:0] d[2]);
        int o;
        if (m_own < 0) begin
            o = -1;
            if (r[0] && r[1]) o = 1 - m_last;
            else if (r[0]) o = 0;
            else if (r[1]) o = 1;
            if (o >= 0) begin
                m_own = o; m_last = o; m_beats = 0;
            end
        end else begin
            o = m_own;
            if (r[o]) begin
                gq.push_back('{cyc, o, w[o], a[o], d[o]});
                if (w[o]) begin
                    m_mem[a[o]] = d[o];
                    if (HI_EN && a[o] > m_hi) m_hi = a[o];
                end else begin
                    rq.push_back('{cyc + 1, o, m_mem[a[o]]});
                end
            end
            if (r[o] && l[o] && m_beats < MB - 1) m_beats++;
            else begin
                m_beats = 0;
                if (r[1 - o]) begin
                    m_own = 1 - o; m_last = 1 - o;
                end else m_own = -1;
            end
        end
    endtask

    // one clock: drive after the edge, run the model, settle past the monitor
    task automatic step(bit r0, bit l0, bit w0, logic [7:0] a0, logic [15:0] d0,
                        bit r1, bit l1, bit w1, logic [7:0] a1, logic [15:0] d1);
        bit r[2]; bit l[2]; bit w[2];
        logic [7:0] a[2]; logic [15:0] d[2];
        @(posedge sys_clk); #1;
        drive(r0, l0, w0, a0, d0, r1, l1, w1, a1, d1);
        r = '{r0, r1}; l = '{l0, l1}; w = '{w0, w1};
        a = '{a0, a1}; d = '{d0, d1};
        model(r, l, w, a, d);
        @(negedge sys_clk); #1;
    endtask

    task automatic idle_step();
        step(0, 0, 0, 8'h00, 16'h0, 0, 0, 0, 8'h00, 16'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 8'h00, 16'h0, 0, 0, 0, 8'h00, 16'h0);
        m_own = -1; m_beats = 0; m_last = 1; m_hi = '0;
        gq.delete(); rq.delete();
        repeat (2) @(posedge sys_clk);
        #1 rst = 1'b0;
    endtask

    always @(negedge sys_clk) begin
        if (!rst) begin
            if (bus.gnt0 || bus.gnt1) begin
                chk("gnt_onehot", {31'b0, bus.gnt0 & bus.gnt1}, 32'd0);
                if (gq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL gnt_unexpected: got gnt0=%0b gnt1=%0b expected none (cycle %0d)",
                             bus.gnt0, bus.gnt1, cyc);
                end else begin
                    gexp_t e;
                    e = gq.pop_front();
                    chk("gnt_cycle", cyc, e.stamp);
                    chk("gnt_id", {31'b0, bus.gnt1}, e.id);
                    chk("mem_we", {31'b0, bus.mem_we}, {31'b0, e.we});
                    chk("mem_a", {24'b0, bus.mem_a}, {24'b0, e.a});
                    if (e.we) chk("mem_d", {16'b0, bus.mem_d}, {16'b0, e.d});
                end
            end else begin
                chk("mem_we_nogrant", {31'b0, bus.mem_we}, 32'd0);
                if (gq.size() != 0 && gq[0].stamp <= cyc) begin
                    checks++; errors++;
                    $display("FAIL gnt_missing: got none expected id %0d (cycle %0d)",
                             gq[0].id, cyc);
                    void'(gq.pop_front());
                end
            end
            if (bus.rvalid0 || bus.rvalid1) begin
                if (rq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rvalid_unexpected: got rv0=%0b rv1=%0b expected none (cycle %0d)",
                             bus.rvalid0, bus.rvalid1, cyc);
                end else begin
                    rexp_t e;
                    e = rq.pop_front();
                    chk("rv_cycle", cyc, e.stamp);
                    chk("rv_id", {31'b0, bus.rvalid1}, e.id);
                    chk("rdata", {16'b0, bus.rdata}, {16'b0, e.d});
                end
            end else if (rq.size() != 0 && rq[0].stamp <= cyc) begin
                checks++; errors++;
                $display("FAIL rvalid_missing: got none expected id %0d (cycle %0d)",
                         rq[0].id, cyc);
                void'(rq.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500us");
        $fatal(1);
    end

    initial begin
        int n0;
        logic [15:0] keep;
        foreach (ram[i]) begin
            ram[i]   = 16'($urandom);
            m_mem[i] = ram[i];
        end
        drive(0, 0, 0, 8'h00, 16'h0, 0, 0, 0, 8'h00, 16'h0);
        rst = 1'b1;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("rst_gnt0", {31'b0, bus.gnt0}, 32'd0);
        chk("rst_gnt1", {31'b0, bus.gnt1}, 32'd0);
        chk("rst_rvalid", {30'b0, bus.rvalid1, bus.rvalid0}, 32'd0);
        chk("rst_rdata", {16'b0, bus.rdata}, 32'd0);
        chk("rst_highest", {24'b0, bus.highest_add}, 32'd0);
        chk("rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
        @(posedge sys_clk); #1 rst = 1'b0;

        // first write, then read back through requester 1
        step(1, 0, 1, 8'h05, 16'h1234, 0, 0, 0, 8'h00, 16'h0);
        chk("w05_c1_gnt0", {31'b0, bus.gnt0}, 32'd0);
        step(1, 0, 1, 8'h05, 16'h1234, 0, 0, 0, 8'h00, 16'h0);
        chk("w05_c2_gnt0", {31'b0, bus.gnt0}, 32'd1);
        chk("w05_mem_we", {31'b0, bus.mem_we}, 32'd1);
        chk("w05_mem_a", {24'b0, bus.mem_a}, 32'h05);
        step(0, 0, 0, 8'h00, 16'h0, 1, 0, 0, 8'h05, 16'h0);
        chk("w05_highest", {24'b0, bus.highest_add}, HI_EN ? 32'h05 : 32'h0);
        chk("r05_c1_gnt1", {31'b0, bus.gnt1}, 32'd0);
        step(0, 0, 0, 8'h00, 16'h0, 1, 0, 0, 8'h05, 16'h0);
        chk("r05_gnt1", {31'b0, bus.gnt1}, 32'd1);
        idle_step();
        chk("r05_rvalid1", {31'b0, bus.rvalid1}, 32'd1);
        chk("r05_rdata", {16'b0, bus.rdata}, 32'h1234);
        idle_step();
        chk("r05_rvalid1_pulse", {31'b0, bus.rvalid1}, 32'd0);
        chk("r05_rdata_hold", {16'b0, bus.rdata}, 32'h1234);

        // both requesting, no lock: strict alternation starting with 0
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 0, 8'(8'h20 + i), 16'h0, 1, 0, 0, 8'(8'h30 + i), 16'h0);
            chk("alt_gnt0", {31'b0, bus.gnt0}, (i % 2 == 1) ? 32'd1 : 32'd0);
            chk("alt_gnt1", {31'b0, bus.gnt1}, (i > 0 && i % 2 == 0) ? 32'd1 : 32'd0);
        end
        idle_step();
        idle_step();

        // locked burst hits the limit and hands over
        do_reset();
        n0 = 0;
        for (int i = 0; i < 18; i++) begin
            step(1, 1, 0, 8'(i), 16'h0, 1, 0, 0, 8'h80, 16'h0);
            if (bus.gnt0) n0++;
            if (i == 17) chk("burst_handover_gnt1", {31'b0, bus.gnt1}, 32'd1);
        end
        chk("burst_gnt0_count", n0, 32'd16);
        idle_step();
        idle_step();

        // lower address after a higher one leaves the tracker alone
        step(1, 0, 1, 8'h10, 16'hAAAA, 0, 0, 0, 8'h00, 16'h0);
        step(1, 0, 1, 8'h10, 16'hAAAA, 0, 0, 0, 8'h00, 16'h0);
        step(1, 0, 1, 8'h03, 16'h5555, 0, 0, 0, 8'h00, 16'h0);
        step(1, 0, 1, 8'h03, 16'h5555, 0, 0, 0, 8'h00, 16'h0);
        idle_step();
        chk("highest_keep", {24'b0, bus.highest_add}, HI_EN ? 32'h10 : 32'h0);

        // reset during the 5th beat of a locked write burst
        do_reset();
        for (int i = 0; i < 6; i++) begin
            keep = (i == 5) ? m_mem[8'h45] : 16'(16'hC000 + i);
            step(1, 1, 1, 8'(8'h40 + i), keep, 0, 0, 0, 8'h00, 16'h0);
        end
        chk("abort_gnt0_before", {31'b0, bus.gnt0}, 32'd1);
        chk("abort_we_before", {31'b0, bus.mem_we}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_gnt0", {31'b0, bus.gnt0}, 32'd0);
        chk("abort_mem_we", {31'b0, bus.mem_we}, 32'd0);
        @(posedge sys_clk);
        @(negedge sys_clk);
        chk("abort_rvalid", {30'b0, bus.rvalid1, bus.rvalid0}, 32'd0);
        do_reset();
        step(1, 0, 0, 8'h05, 16'h0, 0, 0, 0, 8'h00, 16'h0);
        chk("abort_idle_gnt0", {31'b0, bus.gnt0}, 32'd0);
        step(1, 0, 0, 8'h05, 16'h0, 0, 0, 0, 8'h00, 16'h0);
        chk("abort_regrant", {31'b0, bus.gnt0}, 32'd1);

        // a read accepted in the reset cycle yields nothing
        step(1, 0, 0, 8'h05, 16'h0, 0, 0, 0, 8'h00, 16'h0);
        step(1, 0, 0, 8'h05, 16'h0, 0, 0, 0, 8'h00, 16'h0);
        chk("rdrst_gnt0", {31'b0, bus.gnt0}, 32'd1);
        rst = 1'b1;
        @(posedge sys_clk); #1;
        chk("rdrst_rvalid0", {31'b0, bus.rvalid0}, 32'd0);
        chk("rdrst_rdata", {16'b0, bus.rdata}, 32'd0);
        do_reset();

        // randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] a0, a1;
            a0 = ($urandom % 4 == 0) ? 8'(8'hFF - $urandom_range(0, 2)) : 8'($urandom_range(0, 31));
            a1 = ($urandom % 4 == 0) ? 8'(8'hFF - $urandom_range(0, 2)) : 8'($urandom_range(0, 31));
            step($urandom % 4 != 0, $urandom % 3 != 0, $urandom % 2 == 0, a0, 16'($urandom),
                 $urandom % 4 != 0, $urandom % 3 != 0, $urandom % 2 == 0, a1, 16'($urandom));
        end
        repeat (4) idle_step();
        chk("rand_highest", {24'b0, bus.highest_add}, {24'b0, m_hi});
        chk("rand_gq_drained", gq.size(), 32'd0);
        chk("rand_rq_drained", rq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
